// File: rtl/serial_magnitude_comparator_pkg.sv
// rtl/serial_magnitude_comparator_pkg.sv - shared encodings for the bit-serial magnitude comparator
package serial_magnitude_comparator_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Running comparison decision; DEC_EQ doubles as "undecided so far"
  typedef enum logic [1:0] {
    DEC_EQ = 2'd0,
    DEC_GT = 2'd1,
    DEC_LT = 2'd2
  } dec_t;

endpackage

// File: rtl/serial_magnitude_comparator_bit_cell.sv
// rtl/serial_magnitude_comparator_bit_cell.sv - MSB-first sticky decision step for one bit-pair
module comparator_bit_cell
  import serial_magnitude_comparator_pkg::*;
(
  input  dec_t prior,
  input  logic a_bit,
  input  logic b_bit,
  output dec_t next
);

  // The first differing bit (MSB first) settles the result; later bits never override it
  always_comb begin
    next = prior;
    if (prior == DEC_EQ && a_bit != b_bit) begin
      next = a_bit ? DEC_GT : DEC_LT;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial unsigned magnitude comparator, MSB first
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  dec_t          dec;
  dec_t          dec_next;
  logic [CW-1:0] cnt;
  logic          last_beat;

  comparator_bit_cell u_cell (
    .prior (dec),
    .a_bit (a_bit),
    .b_bit (b_bit),
    .next  (dec_next)
  );

  assign last_beat = (state == SHIFT) && bit_valid && (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured outside SHIFT
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_beat) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit counter, running decision and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dec <= DEC_EQ;
      gt  <= 1'b0;
      eq  <= 1'b0;
      lt  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= CNT_LOAD;
            dec <= DEC_EQ;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            dec <= dec_next;
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              // Result lands together with entry into DONE so it is valid while done is high
              gt <= (dec_next == DEC_GT);
              eq <= (dec_next == DEC_EQ);
              lt <= (dec_next == DEC_LT);
            end
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic gt;
  logic eq;
  logic lt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cyc_first;

  serial_magnitude_comparator #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2:0] gel();
    return {gt, eq, lt};
  endfunction

  // Drive start for one cycle; SHIFT must follow
  task automatic do_start(input logic [2:0] prev);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_hold", gel(), prev);
  endtask

  // Feed A/B MSB first; pattern[i] is bit_valid in SHIFT cycle i; start_at injects a stray start
  task automatic feed(input logic [3:0] a, input logic [3:0] b, input logic [15:0] pattern,
                      input int start_at, input logic [2:0] prev, input logic [2:0] exp);
    int idx = 3;
    int i = 0;
    while (idx >= 0 && i < 16) begin
      bit_valid = pattern[i];
      a_bit     = a[idx];
      b_bit     = b[idx];
      start     = (i == start_at);
      tick();
      if (pattern[i]) idx--;
      i++;
      if (idx >= 0) begin
        check("shift_done_low", done, 0);
        check("shift_busy", busy, 1);
        check("shift_hold", gel(), prev);
      end
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    check("feed_bound", (idx < 0), 1);
    check("done_pulse", done, 1);
    check("done_busy_low", busy, 0);
    check("result", gel(), exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;

    // Reset held with random inputs
    for (int k = 0; k < 2; k++) begin
      start = 1'($urandom); bit_valid = 1'($urandom); a_bit = 1'($urandom); b_bit = 1'($urandom);
      tick();
      check("rst_outs", {busy, done, gt, eq, lt}, 0);
    end
    rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
    tick();
    check("post_rst_outs", {busy, done, gt, eq, lt}, 0);

    // A=1010 B=0110 no stalls -> gt
    do_start(3'b000);
    feed(4'b1010, 4'b0110, 16'hFFFF, -1, 3'b000, 3'b100);
    tick();
    check("one_cycle_done", done, 0);
    check("idle_after", busy, 0);
    check("hold_idle", gel(), 3'b100);

    // A=B=1011 with stalls in 2nd and 4th SHIFT cycles -> eq
    do_start(3'b100);
    feed(4'b1011, 4'b1011, 16'b1111_1111_1111_0101, -1, 3'b100, 3'b010);
    tick();

    // A=0011 B=0101 -> lt, stray start in SHIFT cycle 2 ignored
    do_start(3'b010);
    feed(4'b0011, 4'b0101, 16'hFFFF, 1, 3'b010, 3'b001);
    tick();
    check("no_extra_done", done, 0);
    check("no_restart", busy, 0);

    // Back-to-back: 1111/1110 then 0000/1000 with start in DONE cycle
    do_start(3'b001);
    feed(4'b1111, 4'b1110, 16'hFFFF, -1, 3'b001, 3'b100);
    done_cyc_first = cyc;
    do_start(3'b100);
    feed(4'b0000, 4'b1000, 16'hFFFF, -1, 3'b100, 3'b001);
    check("b2b_spacing", cyc - done_cyc_first, 5);
    tick();

    // Reset after 2 accepted bits
    do_start(3'b001);
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outs", {busy, done, gt, eq, lt}, 0);
    for (int k = 0; k < 6; k++) begin
      a_bit = 1'($urandom); b_bit = 1'($urandom);
      tick();
      check("ignored_bits", {busy, done}, 0);
    end
    bit_valid = 1'b0;
    do_start(3'b000);
    feed(4'b0101, 4'b0101, 16'hFFFF, -1, 3'b000, 3'b010);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
